sum_accum: RTL and testbench
============================

# sum_accum

Downstream consumer of the 8-bit adder's 9-bit sum. It accepts one sum per valid/ready handshake and accumulates N sums into a wider total. After the Nth sum it presents the block total and its mean on an output handshake. This lets the adder be exercised and checked over blocks of operand pairs instead of one pair at a time.

## Interface
- `W`, default 9: input sum width; matches the adder's sum output `s`.
- `N`, default 8: sums per block. Must be a power of two, at least 2.
- `AW`, default 12: accumulator and total width. Must satisfy AW ≥ W.

- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `s`, input, W: sum from the adder.
- `in_valid`, input, 1: `s` is valid this cycle.
- `in_ready`, output, 1: block can accept `s` this cycle.
- `total`, output, AW: block total, modulo 2^AW.
- `mean`, output, AW: `total` >> log2(N), truncated.
- `ovf`, output, 1: the block total exceeded 2^AW−1 at least once (sticky per block).
- `out_valid`, output, 1: `total`, `mean` and `ovf` are valid.
- `out_ready`, input, 1: downstream takes the result.
- `count`, output, log2(N)+1: number of sums accepted in the current block.

## Operation
- Two states: ACC and HOLD.
- ACC:
  - `in_ready`=1 and `out_valid`=0.
  - A transfer occurs when `in_valid`=1 and `in_ready`=1.
  - On a transfer: acc ← acc + zero-extended `s`, using an (AW+1)-bit add. The low AW bits are kept.
  - If bit AW of that add is 1, set the sticky `ovf`.
  - `count` increments on each transfer.
  - On the transfer that makes `count`=N: latch the final acc into `total` and the final ovf into `ovf`, then go to HOLD.
- HOLD:
  - `in_ready`=0 and `out_valid`=1.
  - `total`, `mean`, `ovf` and `count`(=N) are held stable.
  - When `out_ready`=1: go to ACC, and clear acc, `count` and `ovf` to 0.
- `mean` is a shift of the registered `total`. It is combinational from `total`, not a separate pipeline stage.
- Width rule: with the defaults, the maximum total is 8×510 = 4080 < 4096, so `ovf` never asserts. Smaller AW wraps the total and sets `ovf`.
- `s` is sampled only on a transfer. Its value is ignored at all other times.

## Timing
- Reset values: state ACC, acc=0, `count`=0, `total`=0, `mean`=0, `ovf`=0, `out_valid`=0.
  - `in_ready` is 1 from the first cycle after reset is released.
- `rst` wins over every other input, including mid-block or during HOLD. All partial accumulation is discarded.
- Latency: `out_valid` rises on the clock edge that captures the Nth transfer. It is visible in the cycle after that transfer.
- Throughput:
  - One sum per cycle in ACC.
  - At least one HOLD cycle per block.
  - Best case is N+1 cycles per block, with `out_ready` held at 1.
- Result acceptance and input in the same cycle:
  - In HOLD, `in_ready`=0, so an `in_valid` that coincides with `out_ready` is not accepted.
  - The upstream must hold `s` and `in_valid` until the next cycle, when the block is back in ACC.
- Back-pressure: `out_valid` and the result outputs stay constant for any number of cycles while `out_ready`=0.
- `in_valid`=0 in ACC is a stall: acc and `count` are unchanged.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random `in_valid`/`s`.
  - Required: `count`=0, `out_valid`=0, `total`=0, `ovf`=0 and `in_ready`=1 after release.
- Ascending block, defaults, `out_ready`=1: stream 0, 3, 6, 12, 24, 48, 96, 192 on consecutive cycles.
  - Required: `out_valid`=1 for one cycle, `total`=381, `mean`=47, `ovf`=0.
  - Required: `in_ready`=0 during that cycle and 1 on the next.
- High block with gaps: stream 128, 130, 135, 143, 159, 191, 255, 383 with `in_valid`=0 between every pair.
  - Required: `total`=1524, `mean`=190, `ovf`=0, and `count` steps 1..8 only on transfers.
- Overflow, AW=10: stream eight × 510.
  - Required: `total`=1008, `mean`=126, `ovf`=1.
  - Required: the next block of eight × 1 gives `total`=8 and `ovf`=0, proving the sticky flag is cleared.
- Back-pressure: complete a block with `out_ready`=0 for 5 cycles and `in_valid`=1 throughout.
  - Required: outputs stable and `in_ready`=0 for all 5 cycles.
  - Required: the sum presented in the release cycle is accepted on the following cycle as `count`=1.
- Reset mid-block: after 3 transfers (10, 20, 30), pulse `rst` for 1 cycle, then stream eight × 1.
  - Required: `total`=8 and `count` restarts at 1 after reset.

Source files
------------

// File: rtl/sum_accum.sv
`default_nettype none
// ============================================================================
// Module  : sum_accum
// Brief   : Accumulates N adder sums per block and presents the total/mean.
// Revision: 1.0 - initial release
// ============================================================================
module sum_accum #(
  parameter int W  = 9,
  parameter int N  = 8,
  parameter int AW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         s,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AW-1:0]        total,
  output logic [AW-1:0]        mean,
  output logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N):0]   count
);

  localparam int SH = $clog2(N);
  localparam int CW = SH + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic          acc_ovf;
  logic [AW:0]   sum;
  logic          xfer;

  // One extra bit on the add exposes the wrap that feeds the sticky flag.
  assign sum       = {1'b0, acc} + {{(AW + 1 - W){1'b0}}, s};
  assign xfer      = (state == ACC) && in_valid;
  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign mean      = total >> SH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      acc     <= '0;
      acc_ovf <= 1'b0;
      count   <= '0;
      total   <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (xfer) begin
            acc     <= sum[AW-1:0];
            acc_ovf <= acc_ovf | sum[AW];
            count   <= count + 1'b1;
            if (count == LAST) begin
              total <= sum[AW-1:0];
              ovf   <= acc_ovf | sum[AW];
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state   <= ACC;
            acc     <= '0;
            acc_ovf <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_sum_accum
// Brief   : Self-checking bench for sum_accum (default AW and AW=10 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] s = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid, ovf;
  logic [11:0] total, mean;
  logic [3:0]  count;
  logic        in_ready10, out_valid10, ovf10;
  logic [9:0]  total10, mean10;
  logic [3:0]  count10;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_accum #(.W(9), .N(8), .AW(12)) dut (
    .clk(clk), .rst(rst), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .total(total), .mean(mean), .ovf(ovf), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  sum_accum #(.W(9), .N(8), .AW(10)) dut10 (
    .clk(clk), .rst(rst), .s(s), .in_valid(in_valid), .in_ready(in_ready10),
    .total(total10), .mean(mean10), .ovf(ovf10), .out_valid(out_valid10),
    .out_ready(out_ready), .count(count10)
  );

  typedef struct {
    logic [8:0] v [8];
    bit         gaps;
    int         t12, m12, t10, m10, o10;
  } blk_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Presents v until accepted; in_valid is left high so callers can stream.
  task automatic xfer(input logic [8:0] v);
    bit done = 0;
    s = v;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      done = in_ready;
      tick();
    end
    if (!done) check("xfer_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  blk_t blocks [4];

  // Reference model state for the random phase
  int q [$];
  bit pending;
  int exp_sum;

  initial begin
    blocks[0].v = '{9'd0, 9'd3, 9'd6, 9'd12, 9'd24, 9'd48, 9'd96, 9'd192};
    blocks[0].gaps = 0;
    blocks[0].t12 = 381;  blocks[0].m12 = 47;  blocks[0].t10 = 381;  blocks[0].m10 = 47;  blocks[0].o10 = 0;
    blocks[1].v = '{9'd128, 9'd130, 9'd135, 9'd143, 9'd159, 9'd191, 9'd255, 9'd383};
    blocks[1].gaps = 1;
    blocks[1].t12 = 1524; blocks[1].m12 = 190; blocks[1].t10 = 500;  blocks[1].m10 = 62;  blocks[1].o10 = 1;
    blocks[2].v = '{9'd510, 9'd510, 9'd510, 9'd510, 9'd510, 9'd510, 9'd510, 9'd510};
    blocks[2].gaps = 0;
    blocks[2].t12 = 4080; blocks[2].m12 = 510; blocks[2].t10 = 1008; blocks[2].m10 = 126; blocks[2].o10 = 1;
    blocks[3].v = '{9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1};
    blocks[3].gaps = 0;
    blocks[3].t12 = 8;    blocks[3].m12 = 1;   blocks[3].t10 = 8;    blocks[3].m10 = 1;   blocks[3].o10 = 0;

    // Reset with random activity on the inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'($urandom);
      s = 9'($urandom_range(0, 510));
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_total", total, 0);
    check("rst_mean", mean, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // Table-driven blocks with out_ready held high
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        xfer(blocks[b].v[i]);
        check("blk_count", count, i + 1);
        if (blocks[b].gaps && i < 7) begin
          in_valid = 1'b0;
          tick();
          check("blk_stall_count", count, i + 1);
        end
      end
      in_valid = 1'b0;
      check("blk_out_valid", out_valid, 1);
      check("blk_in_ready_hold", in_ready, 0);
      check("blk_total", total, blocks[b].t12);
      check("blk_mean", mean, blocks[b].m12);
      check("blk_ovf", ovf, 0);
      check("blk_total10", total10, blocks[b].t10);
      check("blk_mean10", mean10, blocks[b].m10);
      check("blk_ovf10", ovf10, blocks[b].o10);
      tick();
      check("blk_out_valid_drop", out_valid, 0);
      check("blk_in_ready_back", in_ready, 1);
      check("blk_count_clr", count, 0);
    end

    // Back-pressure: result held for 5 cycles with in_valid asserted
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) xfer(9'(i));
    s = 9'd99;
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_total", total, 36);
      check("bp_mean", mean, 4);
      check("bp_count", count, 8);
      if (k < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_count", count, 0);
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_accept_count", count, 1);
    for (int i = 0; i < 7; i++) xfer(9'd1);
    in_valid = 1'b0;
    check("bp_total_next", total, 106);
    check("bp_out_valid_next", out_valid, 1);
    tick();

    // Reset mid-block discards partial accumulation
    xfer(9'd10);
    xfer(9'd20);
    xfer(9'd30);
    in_valid = 1'b0;
    check("mid_count_pre", count, 3);
    do_reset();
    check("mid_count_rst", count, 0);
    for (int i = 0; i < 8; i++) begin
      xfer(9'd1);
      if (i == 0) check("mid_count_restart", count, 1);
    end
    in_valid = 1'b0;
    check("mid_total", total, 8);
    check("mid_ovf", ovf, 0);
    tick();

    // Random traffic against a queue-based reference model
    do_reset();
    q.delete();
    pending = 0;
    for (int c = 0; c < 600; c++) begin
      bit tr, rel;
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      s = 9'($urandom_range(0, 510));
      tr = in_valid && !pending;
      rel = pending && out_ready;
      tick();
      if (rel) begin
        pending = 0;
        q.delete();
      end
      if (tr) begin
        q.push_back(int'(s));
        if (q.size() == 8) begin
          exp_sum = q.sum();
          pending = 1;
        end
      end
      check("rnd_in_ready", in_ready, !pending);
      check("rnd_out_valid", out_valid, pending);
      check("rnd_count", count, q.size());
      check("rnd_in_ready10", in_ready10, !pending);
      if (pending) begin
        check("rnd_total", total, exp_sum % 4096);
        check("rnd_mean", mean, (exp_sum % 4096) / 8);
        check("rnd_ovf", ovf, exp_sum >= 4096);
        check("rnd_total10", total10, exp_sum % 1024);
        check("rnd_mean10", mean10, (exp_sum % 1024) / 8);
        check("rnd_ovf10", ovf10, exp_sum >= 1024);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
